// File: rtl/mux_42.sv
// mux_42: 4-to-1 word multiplexer with a zero-latency combinational output
// and an enable-gated registered copy of the selected word and its select code.
module mux_42 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  input  logic [WIDTH-1:0] din_2,
  input  logic [WIDTH-1:0] din_3,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       sel_onehot,
  output logic [WIDTH-1:0] dout_q,
  output logic [1:0]       sel_q
);

  // Word select: every code decoded; an unknown select yields all-X in simulation
  // rather than quietly falling back to din_0.
  always_comb begin
    dout = {WIDTH{1'bx}};
    case (sel)
      2'd0: dout = din_0;
      2'd1: dout = din_1;
      2'd2: dout = din_2;
      2'd3: dout = din_3;
    endcase
  end

  // One-hot decode of the select code.
  always_comb begin
    sel_onehot = 4'bxxxx;
    case (sel)
      2'd0: sel_onehot = 4'b0001;
      2'd1: sel_onehot = 4'b0010;
      2'd2: sel_onehot = 4'b0100;
      2'd3: sel_onehot = 4'b1000;
    endcase
  end

  // Registered copy: async clear while reset is low, capture on enabled edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      sel_q  <= 2'd0;
    end else if (en) begin
      dout_q <= dout;
      sel_q  <= sel;
    end
  end

endmodule

// File: tb/tb_mux_42.sv
// tb_mux_42: directed-vector bench for mux_42 with hand-computed expectations.
module tb_mux_42;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             en;
  logic [1:0]       sel;
  logic [WIDTH-1:0] din_0, din_1, din_2, din_3;
  logic [WIDTH-1:0] dout;
  logic [3:0]       sel_onehot;
  logic [WIDTH-1:0] dout_q;
  logic [1:0]       sel_q;

  int n_checks;
  int n_fails;

  mux_42 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sel        (sel),
    .din_0      (din_0),
    .din_1      (din_1),
    .din_2      (din_2),
    .din_3      (din_3),
    .dout       (dout),
    .sel_onehot (sel_onehot),
    .dout_q     (dout_q),
    .sel_q      (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s);
    case (s)
      2'd0: pick = din_0;
      2'd1: pick = din_1;
      2'd2: pick = din_2;
      default: pick = din_3;
    endcase
  endfunction

  logic [3:0]  oh_exp [4];
  logic [31:0] d_exp;
  logic [1:0]  s_exp;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    oh_exp[0] = 4'b0001; oh_exp[1] = 4'b0010;
    oh_exp[2] = 4'b0100; oh_exp[3] = 4'b1000;

    reset = 1'b0;
    en    = 1'b1;
    sel   = 2'd0;
    din_0 = 32'd0; din_1 = 32'd1; din_2 = 32'd2; din_3 = 32'd3;

    // Reset state: registers clear, combinational path still live.
    #1;
    check("rst_dout_q", dout_q, 32'd0);
    check("rst_sel_q", {30'd0, sel_q}, 32'd0);

    // Static select and one-hot sweep (during reset, combinational path follows).
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("static_dout_%0d", i), dout, 32'(i));
      check($sformatf("onehot_%0d", i), {28'd0, sel_onehot}, {28'd0, oh_exp[i]});
    end

    // Registers stay cleared across an edge while reset is held.
    @(posedge clk); #1;
    check("rst_hold_dout_q", dout_q, 32'd0);

    // Counter-driven select: release reset, sel counts 0,1,2,3,0,... each cycle.
    din_0 = 32'h1111_0000; din_1 = 32'h2222_0001;
    din_2 = 32'h3333_0002; din_3 = 32'h4444_0003;
    @(negedge clk);
    reset = 1'b1;
    sel   = 2'd0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("cnt_dout_%0d", k), dout, pick(sel));
      d_exp = pick(sel);
      s_exp = sel;
      @(posedge clk); #1;
      check($sformatf("cnt_dout_q_%0d", k), dout_q, d_exp);
      check($sformatf("cnt_sel_q_%0d", k), {30'd0, sel_q}, {30'd0, s_exp});
      @(negedge clk);
      sel = sel + 2'd1;
    end

    // Data change under fixed select; non-selected input must not disturb dout.
    din_0 = 32'd0; din_1 = 32'd1; din_2 = 32'd2; din_3 = 32'd3;
    sel = 2'd2;
    #1;
    check("fixed_sel_dout", dout, 32'd2);
    din_2 = 32'hDEAD_BEEF;
    #1;
    check("din2_change", dout, 32'hDEAD_BEEF);
    din_0 = 32'hFFFF_FFFF;
    #1;
    check("din0_no_effect", dout, 32'hDEAD_BEEF);

    // Registered path and enable hold.
    @(negedge clk);
    en = 1'b1; sel = 2'd3;
    @(posedge clk); #1;
    check("reg_dout_q", dout_q, 32'd3);
    check("reg_sel_q", {30'd0, sel_q}, 32'd3);
    @(negedge clk);
    en = 1'b0; sel = 2'd1;
    @(posedge clk); #1;
    check("hold_dout_q", dout_q, 32'd3);
    check("hold_sel_q", {30'd0, sel_q}, 32'd3);
    check("hold_dout", dout, 32'd1);

    // Async reset between edges: immediate clear, dout unaffected.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_dout_q", dout_q, 32'd0);
    check("async_sel_q", {30'd0, sel_q}, 32'd0);
    check("async_dout", dout, 32'd1);
    en = 1'b1; sel = 2'd3;
    @(posedge clk); #1;
    check("async_hold_dout_q", dout_q, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reload_dout_q", dout_q, 32'd3);
    check("reload_sel_q", {30'd0, sel_q}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
